// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Purpose: shared definitions for the command-RAM arbiter.
//   - Command word layout: {opcode[1:0], payload[7:0]}.
//   - Opcode values understood by the RAM command decoder.
//   - Arbiter state encoding.
// Ports: none (package).
package ram_arb_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arb_timer.sv
// ram_arb_timer
// Purpose: saturating cycle counter with a combinational expiry flag.
//   The flag is raised during the i_limit-th consecutive enabled cycle,
//   so the owner of the timer can react in that same cycle.
// Ports:
//   clk        in  1  rising-edge clock
//   rst_n      in  1  asynchronous active-low reset
//   i_clear    in  1  synchronous clear (has priority over counting)
//   i_enable   in  1  count this cycle
//   i_limit    in  W  number of enabled cycles before expiry
//   o_expired  out 1  high during the cycle that reaches i_limit
module ram_arb_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_limit,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // Count enabled cycles, holding at the limit instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != i_limit)) begin
            r_count <= r_count + W'(1);
        end
    end

    // Flag the cycle in which the limit-th enabled cycle is happening.
    assign o_expired = i_enable && (r_count == (i_limit - W'(1)));

endmodule

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter
// Purpose: shares the single-port 256x8 command RAM between port 0 (SPI slave)
//   and port 1 (local host/debug master). Round-robin grant in IDLE; after an
//   address opcode the granting port keeps the RAM until its data opcode, a
//   re-lock, or a lock timeout. Read data is routed back to the issuing port.
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   i_reqN_valid, i_reqN_cmd   port N command handshake (N = 0, 1)
//   o_reqN_ready               port N may issue this cycle
//   o_rspN_valid, o_rspN_data  port N read response (1-cycle pulse)
//   o_ram_din, o_ram_rx_valid  registered command strobe to the RAM
//   i_ram_tx_valid, i_ram_dout RAM read-data strobe and data
//   o_owner                    current / last granted port
//   o_busy                     arbiter not in IDLE
//   o_timeout_err              1-cycle pulse on lock or read timeout
module ram_cmd_arbiter
    import ram_arb_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 64,
    parameter int RD_TIMEOUT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req0_valid,
    input  logic [CMD_W-1:0]  i_req0_cmd,
    output logic              o_req0_ready,
    output logic              o_rsp0_valid,
    output logic [DATA_W-1:0] o_rsp0_data,
    input  logic              i_req1_valid,
    input  logic [CMD_W-1:0]  i_req1_cmd,
    output logic              o_req1_ready,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp1_data,
    output logic [CMD_W-1:0]  o_ram_din,
    output logic              o_ram_rx_valid,
    input  logic              i_ram_tx_valid,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic              o_owner,
    output logic              o_busy,
    output logic              o_timeout_err
);

    localparam int TMR_MAX = (LOCK_TIMEOUT > RD_TIMEOUT) ? LOCK_TIMEOUT : RD_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] LOCK_LIMIT = TMR_W'(LOCK_TIMEOUT);
    localparam logic [TMR_W-1:0] RD_LIMIT   = TMR_W'(RD_TIMEOUT);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    logic              r_owner;
    logic              r_rrPtr;
    logic              r_timeoutErr;
    logic [CMD_W-1:0]  r_ramDin;
    logic              r_ramRxValid;
    logic              r_rsp0Valid;
    logic              r_rsp1Valid;
    logic [DATA_W-1:0] r_rsp0Data;
    logic [DATA_W-1:0] r_rsp1Data;

    logic              w_ready0;
    logic              w_ready1;
    logic              w_accept;
    logic              w_accPort;
    logic [CMD_W-1:0]  w_accCmd;
    logic [1:0]        w_accOp;
    logic              w_nextOwner;
    logic              w_nextRrPtr;
    logic              w_timeoutHit;
    logic              w_rspFire;
    logic              w_lockExpired;
    logic              w_rdExpired;

    // Ready offer. In IDLE the preferred port is always offered; the other
    // port only when the preferred one is not asking, so at most one accept
    // can happen and no port's ready looks at its own valid.
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_rrPtr == 1'b0) begin
                    w_ready0 = 1'b1;
                    w_ready1 = !i_req0_valid;
                end else begin
                    w_ready1 = 1'b1;
                    w_ready0 = !i_req1_valid;
                end
            end
            LOCKED: begin
                w_ready0 = !r_owner;
                w_ready1 = r_owner;
            end
            default: begin
                w_ready0 = 1'b0;
                w_ready1 = 1'b0;
            end
        endcase
    end

    assign w_accept  = (i_req0_valid && w_ready0) || (i_req1_valid && w_ready1);
    assign w_accPort = i_req1_valid && w_ready1;
    assign w_accCmd  = w_accPort ? i_req1_cmd : i_req0_cmd;
    assign w_accOp   = w_accCmd[CMD_W-1:CMD_W-2];

    // Lock timer runs only on locked cycles where the owner issues nothing.
    ram_arb_timer #(.W(TMR_W)) u_lockTimer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   ((r_state != LOCKED) || w_accept),
        .i_enable  ((r_state == LOCKED) && !w_accept),
        .i_limit   (LOCK_LIMIT),
        .o_expired (w_lockExpired)
    );

    // Read timer runs while waiting for the RAM's read strobe.
    ram_arb_timer #(.W(TMR_W)) u_rdTimer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state != RD_WAIT),
        .i_enable  ((r_state == RD_WAIT) && !i_ram_tx_valid),
        .i_limit   (RD_LIMIT),
        .o_expired (w_rdExpired)
    );

    // Next-state logic. A real owner accept or a returning read always beats
    // a timer expiring in the same cycle.
    always_comb begin
        w_nextState  = r_state;
        w_nextOwner  = r_owner;
        w_nextRrPtr  = r_rrPtr;
        w_timeoutHit = 1'b0;
        w_rspFire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextOwner = w_accPort;
                    w_nextRrPtr = !w_accPort;
                    case (w_accOp)
                        OP_WR_ADDR, OP_RD_ADDR: w_nextState = LOCKED;
                        OP_RD_DATA:             w_nextState = RD_WAIT;
                        default:                w_nextState = IDLE;
                    endcase
                end
            end
            LOCKED: begin
                if (w_accept) begin
                    case (w_accOp)
                        OP_WR_DATA: w_nextState = IDLE;
                        OP_RD_DATA: w_nextState = RD_WAIT;
                        default:    w_nextState = LOCKED;
                    endcase
                end else if (w_lockExpired) begin
                    w_nextState  = IDLE;
                    w_nextRrPtr  = !r_owner;
                    w_timeoutHit = 1'b1;
                end
            end
            RD_WAIT: begin
                if (i_ram_tx_valid) begin
                    w_nextState = IDLE;
                    w_rspFire   = 1'b1;
                end else if (w_rdExpired) begin
                    w_nextState  = IDLE;
                    w_timeoutHit = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Control registers: state, ownership, round-robin pointer, error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_rrPtr      <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_owner      <= w_nextOwner;
            r_rrPtr      <= w_nextRrPtr;
            r_timeoutErr <= w_timeoutHit;
        end
    end

    // Datapath registers: RAM command strobe and per-port read responses.
    // Response data only changes for the port that receives a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ramDin     <= '0;
            r_ramRxValid <= 1'b0;
            r_rsp0Valid  <= 1'b0;
            r_rsp1Valid  <= 1'b0;
            r_rsp0Data   <= '0;
            r_rsp1Data   <= '0;
        end else begin
            r_ramRxValid <= w_accept;
            if (w_accept) begin
                r_ramDin <= w_accCmd;
            end
            r_rsp0Valid <= w_rspFire && !r_owner;
            r_rsp1Valid <= w_rspFire && r_owner;
            if (w_rspFire && !r_owner) begin
                r_rsp0Data <= i_ram_dout;
            end
            if (w_rspFire && r_owner) begin
                r_rsp1Data <= i_ram_dout;
            end
        end
    end

    // Ready is forced low while reset is held so nothing looks accepted.
    assign o_req0_ready   = w_ready0 && rst_n;
    assign o_req1_ready   = w_ready1 && rst_n;
    assign o_rsp0_valid   = r_rsp0Valid;
    assign o_rsp0_data    = r_rsp0Data;
    assign o_rsp1_valid   = r_rsp1Valid;
    assign o_rsp1_data    = r_rsp1Data;
    assign o_ram_din      = r_ramDin;
    assign o_ram_rx_valid = r_ramRxValid;
    assign o_owner        = r_owner;
    assign o_busy         = (r_state != IDLE);
    assign o_timeout_err  = r_timeoutErr;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// tb_ram_cmd_arbiter
// Purpose: self-checking bench for ram_cmd_arbiter. A transaction-level
//   reference model (who holds the RAM, whether a read is outstanding, how
//   long it has been quiet, who is favoured next) predicts every output each
//   cycle. Directed scenarios are followed by randomized traffic.
// Ports: none (top-level bench).
module tb_ram_cmd_arbiter;
    import ram_arb_pkg::*;

    localparam int LOCK_TIMEOUT = 64;
    localparam int RD_TIMEOUT   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0Valid = 1'b0;
    logic [9:0]  req0Cmd = '0;
    logic        req0Ready;
    logic        rsp0Valid;
    logic [7:0]  rsp0Data;
    logic        req1Valid = 1'b0;
    logic [9:0]  req1Cmd = '0;
    logic        req1Ready;
    logic        rsp1Valid;
    logic [7:0]  rsp1Data;
    logic [9:0]  ramDin;
    logic        ramRxValid;
    logic        ramTxValid = 1'b0;
    logic [7:0]  ramDout = '0;
    logic        owner;
    logic        busy;
    logic        timeoutErr;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: RAM holder (-1 = free), outstanding read, quiet-cycle ages.
    int         mLockHolder;
    bit         mReading;
    int         mIdleAge;
    int         mReadAge;
    int         mFavoured;
    int         mOwner;
    logic [9:0] expDin;
    bit         expRx;
    bit         expRspValid [2];
    logic [7:0] expRspData [2];
    bit         expErr;

    always #5 clk = ~clk;

    ram_cmd_arbiter #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .RD_TIMEOUT   (RD_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req0_valid   (req0Valid),
        .i_req0_cmd     (req0Cmd),
        .o_req0_ready   (req0Ready),
        .o_rsp0_valid   (rsp0Valid),
        .o_rsp0_data    (rsp0Data),
        .i_req1_valid   (req1Valid),
        .i_req1_cmd     (req1Cmd),
        .o_req1_ready   (req1Ready),
        .o_rsp1_valid   (rsp1Valid),
        .o_rsp1_data    (rsp1Data),
        .o_ram_din      (ramDin),
        .o_ram_rx_valid (ramRxValid),
        .i_ram_tx_valid (ramTxValid),
        .i_ram_dout     (ramDout),
        .o_owner        (owner),
        .o_busy         (busy),
        .o_timeout_err  (timeoutErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        mLockHolder    = -1;
        mReading       = 1'b0;
        mIdleAge       = 0;
        mReadAge       = 0;
        mFavoured      = 0;
        mOwner         = 0;
        expDin         = '0;
        expRx          = 1'b0;
        expRspValid[0] = 1'b0;
        expRspValid[1] = 1'b0;
        expRspData[0]  = '0;
        expRspData[1]  = '0;
        expErr         = 1'b0;
    endtask

    function automatic bit reqValid(input int p);
        return (p == 0) ? req0Valid : req1Valid;
    endfunction

    // Who may issue right now, from the model's view of the RAM.
    function automatic bit expReady(input int p);
        if (mReading)          return 1'b0;
        if (mLockHolder >= 0)  return (mLockHolder == p);
        if (p == mFavoured)    return 1'b1;
        return !reqValid(mFavoured);
    endfunction

    task automatic compareAll();
        checkOutput("req0_ready", 32'(req0Ready), 32'(expReady(0)));
        checkOutput("req1_ready", 32'(req1Ready), 32'(expReady(1)));
        checkOutput("ram_rx_valid", 32'(ramRxValid), 32'(expRx));
        checkOutput("ram_din", 32'(ramDin), 32'(expDin));
        checkOutput("rsp0_valid", 32'(rsp0Valid), 32'(expRspValid[0]));
        checkOutput("rsp1_valid", 32'(rsp1Valid), 32'(expRspValid[1]));
        checkOutput("rsp0_data", 32'(rsp0Data), 32'(expRspData[0]));
        checkOutput("rsp1_data", 32'(rsp1Data), 32'(expRspData[1]));
        checkOutput("owner", 32'(owner), 32'(mOwner));
        checkOutput("busy", 32'(busy), 32'((mLockHolder >= 0) || mReading));
        checkOutput("timeout_err", 32'(timeoutErr), 32'(expErr));
    endtask

    // Advance the model across the coming clock edge using the current inputs.
    task automatic stepModel();
        int         winner;
        logic [9:0] cmd;
        winner = -1;
        if (expReady(0) && req0Valid)      winner = 0;
        else if (expReady(1) && req1Valid) winner = 1;
        expRx          = 1'b0;
        expErr         = 1'b0;
        expRspValid[0] = 1'b0;
        expRspValid[1] = 1'b0;
        if (mReading) begin
            if (ramTxValid) begin
                expRspValid[mOwner] = 1'b1;
                expRspData[mOwner]  = ramDout;
                mReading = 1'b0;
            end else begin
                mReadAge++;
                if (mReadAge >= RD_TIMEOUT) begin
                    mReading = 1'b0;
                    expErr   = 1'b1;
                end
            end
        end else if (winner >= 0) begin
            cmd    = (winner == 1) ? req1Cmd : req0Cmd;
            expRx  = 1'b1;
            expDin = cmd;
            if (mLockHolder < 0) begin
                mOwner    = winner;
                mFavoured = 1 - winner;
            end
            case (cmd[9:8])
                OP_WR_ADDR, OP_RD_ADDR: begin
                    mLockHolder = winner;
                    mIdleAge    = 0;
                end
                OP_WR_DATA: mLockHolder = -1;
                default: begin
                    mLockHolder = -1;
                    mReading    = 1'b1;
                    mReadAge    = 0;
                end
            endcase
        end else if (mLockHolder >= 0) begin
            mIdleAge++;
            if (mIdleAge >= LOCK_TIMEOUT) begin
                mLockHolder = -1;
                mFavoured   = 1 - mOwner;
                expErr      = 1'b1;
            end
        end
    endtask

    // One clock cycle: drive after the edge, check at mid-cycle, advance model.
    task automatic applyStimulus(input bit v0, input logic [9:0] c0, input bit v1,
                                 input logic [9:0] c1, input bit tx, input logic [7:0] dout);
        @(posedge clk);
        #1;
        req0Valid  = v0;
        req0Cmd    = c0;
        req1Valid  = v1;
        req1Cmd    = c1;
        ramTxValid = tx;
        ramDout    = dout;
        #4;
        compareAll();
        stepModel();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        req0Valid  = 1'b0;
        req0Cmd    = '0;
        req1Valid  = 1'b0;
        req1Cmd    = '0;
        ramTxValid = 1'b0;
        ramDout    = '0;
        #4;
        checkOutput("rst_req0_ready", 32'(req0Ready), 32'd0);
        checkOutput("rst_req1_ready", 32'(req1Ready), 32'd0);
        checkOutput("rst_ram_rx_valid", 32'(ramRxValid), 32'd0);
        checkOutput("rst_ram_din", 32'(ramDin), 32'd0);
        checkOutput("rst_rsp0_valid", 32'(rsp0Valid), 32'd0);
        checkOutput("rst_rsp1_valid", 32'(rsp1Valid), 32'd0);
        checkOutput("rst_rsp0_data", 32'(rsp0Data), 32'd0);
        checkOutput("rst_rsp1_data", 32'(rsp1Data), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeoutErr), 32'd0);
        resetModel();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic randomCycle(input int validPct);
        bit         v0;
        bit         v1;
        bit         tx;
        logic [9:0] c0;
        logic [9:0] c1;
        logic [7:0] d;
        v0 = ($urandom_range(99) < validPct);
        v1 = ($urandom_range(99) < validPct);
        tx = ($urandom_range(99) < 30);
        c0 = 10'($urandom);
        c1 = 10'($urandom);
        d  = 8'($urandom);
        applyStimulus(v0, c0, v1, c1, tx, d);
    endtask

    initial begin
        resetModel();
        doReset();

        // Reset state seen after release, plus address/data write pair from port 0.
        idleCycle();
        checkOutput("t1_idle_ready0", 32'(req0Ready), 32'd1);
        applyStimulus(1'b1, 10'h012, 1'b0, 10'h000, 1'b0, 8'h00);
        applyStimulus(1'b1, 10'h1A5, 1'b1, 10'h177, 1'b0, 8'h00);
        checkOutput("t1_locked_ready1", 32'(req1Ready), 32'd0);
        checkOutput("t1_first_rx", 32'(ramRxValid), 32'd1);
        checkOutput("t1_first_din", 32'(ramDin), 32'h012);
        idleCycle();
        checkOutput("t1_second_din", 32'(ramDin), 32'h1A5);
        checkOutput("t1_idle_after", 32'(busy), 32'd0);
        idleCycle();
        checkOutput("t1_rx_single", 32'(ramRxValid), 32'd0);

        // Locked read: response three cycles after the read-data accept.
        doReset();
        applyStimulus(1'b1, 10'h212, 1'b0, 10'h000, 1'b0, 8'h00);
        applyStimulus(1'b1, 10'h300, 1'b0, 10'h000, 1'b0, 8'h00);
        idleCycle();
        applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'hA5);
        checkOutput("t2_rsp_not_early", 32'(rsp0Valid), 32'd0);
        idleCycle();
        checkOutput("t2_rsp0_valid", 32'(rsp0Valid), 32'd1);
        checkOutput("t2_rsp0_data", 32'(rsp0Data), 32'hA5);
        checkOutput("t2_rsp1_quiet", 32'(rsp1Valid), 32'd0);
        idleCycle();
        checkOutput("t2_rsp0_pulse", 32'(rsp0Valid), 32'd0);
        checkOutput("t2_rsp0_hold", 32'(rsp0Data), 32'hA5);

        // Both ports streaming unpaired writes alternate strictly.
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 10'h100 + 10'(k), 1'b1, 10'h140 + 10'(k), 1'b0, 8'h00);
            checkOutput("t3_alt_ready0", 32'(req0Ready), 32'((k % 2) == 0));
            checkOutput("t3_alt_ready1", 32'(req1Ready), 32'((k % 2) == 1));
        end
        idleCycle();

        // Port 1 locks and goes silent: forced release after the lock timeout.
        doReset();
        applyStimulus(1'b0, 10'h000, 1'b1, 10'h234, 1'b0, 8'h00);
        checkOutput("t4_grant1", 32'(req1Ready), 32'd1);
        for (int i = 2; i <= 70; i++) begin
            idleCycle();
            checkOutput("t4_timeout_err", 32'(timeoutErr), 32'(i == LOCK_TIMEOUT + 2));
            checkOutput("t4_busy", 32'(busy), 32'(i < LOCK_TIMEOUT + 2));
        end
        applyStimulus(1'b1, 10'h155, 1'b1, 10'h166, 1'b0, 8'h00);
        checkOutput("t4_next_ready0", 32'(req0Ready), 32'd1);
        checkOutput("t4_next_ready1", 32'(req1Ready), 32'd0);
        idleCycle();

        // Unpaired read that the RAM never answers.
        doReset();
        applyStimulus(1'b1, 10'h300, 1'b0, 10'h000, 1'b0, 8'h00);
        for (int i = 2; i <= 8; i++) begin
            idleCycle();
            checkOutput("t5_timeout_err", 32'(timeoutErr), 32'(i == RD_TIMEOUT + 2));
            checkOutput("t5_no_rsp", 32'(rsp0Valid), 32'd0);
        end

        // Reset in the middle of a read; the late strobe must be ignored.
        doReset();
        applyStimulus(1'b1, 10'h300, 1'b0, 10'h000, 1'b0, 8'h00);
        idleCycle();
        checkOutput("t6_in_read", 32'(busy), 32'd1);
        doReset();
        applyStimulus(1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'hA5);
        idleCycle();
        checkOutput("t6_no_rsp0", 32'(rsp0Valid), 32'd0);
        checkOutput("t6_rsp0_data", 32'(rsp0Data), 32'd0);
        checkOutput("t6_rx", 32'(ramRxValid), 32'd0);
        checkOutput("t6_din", 32'(ramDin), 32'd0);
        checkOutput("t6_err", 32'(timeoutErr), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);

        // Randomized traffic: busy phase, then sparse phase so timeouts occur.
        doReset();
        for (int n = 0; n < 800; n++) begin
            randomCycle(60);
        end
        for (int n = 0; n < 1200; n++) begin
            randomCycle(3);
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
